edge_event_scheduler: RTL and testbench
=======================================

Name: edge_event_scheduler

Overview:
- Watches CHANNELS asynchronous sense lines and detects edges per channel, with the edge type chosen per channel.
- Latches each detected edge as a pending event and delivers events one at a time to a single consumer over a valid/ready port.
- Serialises events by round-robin arbitration between channels.
- Sits between raw pin/status inputs and the shared event consumer (interrupt or status sequencer), replacing per-channel free-running edge pulses that the consumer could miss.

Parameters:
- CHANNELS, 4, number of sense channels; 2..16.
- SYNC_STAGES, 2, synchroniser flops per sense bit; 0 means inputs are already synchronous.
- IDX_W (localparam), $clog2(CHANNELS), width of the channel index.

Ports:
- clk_i  in  1  block clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- clk_en_i  in  1  qualifier; when low, no state changes except synchroniser flops.
- enable_i  in  1  global detect enable.
- sense_i  in  CHANNELS  raw sense lines.
- edge_sel_i  in  2*CHANNELS  per channel [2c+1:2c]: 00 none, 01 rising, 10 falling, 11 both.
- evt_valid_o  out  1  event available.
- evt_ready_i  in  1  consumer accepts event.
- evt_chan_o  out  IDX_W  channel of presented event.
- evt_rising_o  out  1  1 = rising edge, 0 = falling edge.
- pending_o  out  CHANNELS  pending-event flags.
- overflow_o  out  CHANNELS  sticky per-channel lost-event flags.
- overflow_clr_i  in  CHANNELS  per-channel overflow clear.

Behaviour:
- Reset values (async on rst_n_i low): all outputs 0; synchronisers 0; prev 0; rr_ptr = CHANNELS-1; primed = 0.
- Synchroniser: free-running SYNC_STAGES flop chain, ungated. Its output is the sample s[c].
- Sample and prime, on each clk_en_i cycle:
  - prev[c] <= s[c] always, regardless of enable_i.
  - primed <= 1.
  - No edge is detected while primed = 0, so a high line at reset release gives no event.
- Edge detect (combinational, only with clk_en_i & enable_i & primed):
  - rise[c] = ~prev[c] & s[c] & sel[c][0].
  - fall[c] = prev[c] & ~s[c] & sel[c][1].
  - Edges present while enable_i is low are discarded, with no event when enable returns.
- Pending register per channel holds {pend, pol}.
  - New edge with pend = 0: pend <= 1, pol <= rise.
  - New edge with pend = 1 and the channel not being loaded into the slot this cycle: overflow[c] <= 1, and the stored event is kept (oldest wins).
  - New edge in the same cycle the channel is loaded into the slot: pend reloads with the new edge, no overflow.
- Output slot is a single registered entry.
  - Transfer = evt_valid_o & evt_ready_i & clk_en_i.
  - The slot is free when evt_valid_o = 0 or a transfer occurs.
  - When the slot is free and any pend is set, the arbiter grants the first pending channel searching from rr_ptr+1 with wrap.
  - On grant: the slot loads {chan, pol}; that pend clears; rr_ptr <= granted channel; evt_valid_o <= 1.
  - When the slot is free and nothing is pending: evt_valid_o <= 0.
- Stability: evt_chan_o and evt_rising_o are held stable while evt_valid_o = 1 and no transfer has occurred. Back-to-back transfers give one event per cycle.
- Latency (SYNC_STAGES = 0): edge visible on s in cycle t; pend set at t+1; evt_valid_o at t+2 if the slot is free. Each sync stage adds one cycle.
- Overflow priority: overflow_clr_i clears the flag, but a set in the same cycle wins. Clear is gated by clk_en_i.
- Width rule: channels ≥ CHANNELS do not exist; rr_ptr wraps modulo CHANNELS.
- edge_sel_i changing mid-operation affects only future detections; pending events are retained.

Decomposition:
- edge_sched_pkg holds:
  - edge_sel_e enum {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH}.
  - evt_t struct {chan, rising}, parameterised by width through the module.
  - Helper function next_rr_grant for reference.
- Sub-module rr_picker: combinational round-robin first-set search from (ptr+1) with wrap. Ports: req[CHANNELS], ptr, gnt_valid, gnt_idx.
  - Instantiated once.
  - Reused by the bench as the reference model.

Test Plan:
- Reset release with sense_i = 4'b1111 and all channels set to both edges → no evt_valid_o ever; pending_o = 0 after 5 cycles.
- Ch2 rising-only, ready held 1, SYNC_STAGES = 0, sense_i[2] 0→1 at cycle t → evt_valid_o = 1 at t+2 with chan = 2, rising = 1 for exactly 1 cycle. A 1→0 transition produces nothing.
- Ready held 0; ch0, ch1, ch3 rise together; rr_ptr = 3 → after release of ready, events are delivered in order 0, 1, 3, one per cycle, and valid drops after the third.
- Ready 0; ch1 set to both edges toggles 0→1→0 → one event (rising = 1); overflow_o[1] = 1; pulsing overflow_clr_i[1] clears it; a new edge asserted together with the clear leaves it at 1.
- clk_en_i held low for 10 cycles while sense toggles and ready = 1 → no state change, evt_valid_o stays constant; edges present only on the sync output while clk_en_i is low are not detected.
- rst_n_i asserted mid-stream (valid = 1, 2 pending) → outputs 0 immediately and asynchronously; after release, channel 0 gets the first grant on a new edge.

Source files
------------

// File: rtl/edge_sched_pkg.sv
// Shared types and helpers for the edge event scheduler.
//   edge_sel_e    : per-channel edge selection encoding (2 bits per channel)
//   next_rr_grant : round-robin first-set search from (ptr+1) with wrap over
//                   n channels; returns {valid, idx[3:0]}
package edge_sched_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_sel_e;

    localparam int unsigned MAX_CHANNELS = 16;

    // Searches req starting at ptr+1 and wrapping modulo n; the channel at
    // ptr itself is visited last so the previous winner has lowest priority.
    function automatic logic [4:0] next_rr_grant(input logic [15:0]  req,
                                                 input logic [3:0]   ptr,
                                                 input int unsigned  n);
        logic [4:0]  res;
        int unsigned cand;
        res = 5'd0;
        for (int unsigned k = 1; k <= MAX_CHANNELS; k++) begin
            cand = (32'(ptr) + k) % n;
            if ((k <= n) && (res[4] == 1'b0) && req[cand[3:0]]) begin
                res = {1'b1, cand[3:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req       : per-channel request flags
//   ptr       : last granted channel; search begins at ptr+1 and wraps
//   gnt_valid : at least one request present
//   gnt_idx   : selected channel (meaningful only when gnt_valid = 1)
module rr_picker
    import edge_sched_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int IDX_W   = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic                gnt_valid,
    output logic [IDX_W-1:0]    gnt_idx
);

    logic [4:0] res_s;

    assign res_s     = next_rr_grant(16'(req), 4'(ptr), CHANNELS);
    assign gnt_valid = res_s[4];
    assign gnt_idx   = IDX_W'(res_s[3:0]);

endmodule

// File: rtl/edge_event_scheduler.sv
// Edge event scheduler: detects per-channel edges on asynchronous sense
// lines, latches them as pending events and serialises them round-robin
// onto a single valid/ready event port.
//   clk_i, rst_n_i      : clock, async active-low reset
//   clk_en_i            : qualifier; only the synchroniser runs when low
//   enable_i            : global detect enable (edges seen while low are lost)
//   sense_i             : raw sense lines
//   edge_sel_i          : per channel [2c+1:2c] none/rise/fall/both
//   evt_valid_o/ready_i : event handshake; evt_chan_o / evt_rising_o payload
//   pending_o           : pending-event flags
//   overflow_o          : sticky lost-event flags, cleared by overflow_clr_i
module edge_event_scheduler
    import edge_sched_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W      = $clog2(CHANNELS)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic                  enable_i,
    input  logic [CHANNELS-1:0]   sense_i,
    input  logic [2*CHANNELS-1:0] edge_sel_i,
    output logic                  evt_valid_o,
    input  logic                  evt_ready_i,
    output logic [IDX_W-1:0]      evt_chan_o,
    output logic                  evt_rising_o,
    output logic [CHANNELS-1:0]   pending_o,
    output logic [CHANNELS-1:0]   overflow_o,
    input  logic [CHANNELS-1:0]   overflow_clr_i
);

    typedef struct packed {
        logic [IDX_W-1:0] chan;
        logic             rising;
    } evt_t;

    logic [CHANNELS-1:0] samp_s;
    logic [CHANNELS-1:0] prev_r, prev_nxt_s;
    logic                primed_r, primed_nxt_s;
    logic [CHANNELS-1:0] pend_r, pend_nxt_s;
    logic [CHANNELS-1:0] pol_r, pol_nxt_s;
    logic [CHANNELS-1:0] ovf_r, ovf_nxt_s;
    logic                valid_r, valid_nxt_s;
    evt_t                slot_r, slot_nxt_s;
    logic [IDX_W-1:0]    rr_ptr_r, rr_ptr_nxt_s;

    logic                det_en_s;
    logic [CHANNELS-1:0] rise_s, fall_s, edge_s;
    logic                xfer_s, free_s, grant_s;
    logic                gnt_valid_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic [CHANNELS-1:0] load_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign samp_s = sense_i;
        end else begin : g_sync
            logic [CHANNELS-1:0] sync_r [SYNC_STAGES];

            // Free-running synchroniser chain; deliberately not gated by clk_en_i
            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    for (int i = 0; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= '0;
                    end
                end else begin
                    sync_r[0] <= sense_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign samp_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    // No detection until one qualified sample has been taken, so a line
    // that is already high at reset release does not look like a rise.
    assign det_en_s = clk_en_i & enable_i & primed_r;

    // Edge detection per channel according to its selected edge type
    always_comb begin
        rise_s = '0;
        fall_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (edge_sel_e'(edge_sel_i[2*c +: 2]))
                EDGE_NONE: begin
                    rise_s[c] = 1'b0;
                    fall_s[c] = 1'b0;
                end
                EDGE_RISE: begin
                    rise_s[c] = det_en_s & ~prev_r[c] & samp_s[c];
                    fall_s[c] = 1'b0;
                end
                EDGE_FALL: begin
                    rise_s[c] = 1'b0;
                    fall_s[c] = det_en_s & prev_r[c] & ~samp_s[c];
                end
                EDGE_BOTH: begin
                    rise_s[c] = det_en_s & ~prev_r[c] & samp_s[c];
                    fall_s[c] = det_en_s & prev_r[c] & ~samp_s[c];
                end
                default: begin
                    rise_s[c] = 1'b0;
                    fall_s[c] = 1'b0;
                end
            endcase
        end
    end

    assign edge_s = rise_s | fall_s;

    // Slot handshake: the slot can accept a new event when empty or draining
    assign xfer_s  = valid_r & evt_ready_i & clk_en_i;
    assign free_s  = ~valid_r | xfer_s;
    assign grant_s = clk_en_i & free_s & gnt_valid_s;
    assign load_s  = grant_s ? (CHANNELS'(1'b1) << gnt_idx_s) : '0;

    rr_picker #(
        .CHANNELS (CHANNELS)
    ) u_rr_picker (
        .req       (pend_r),
        .ptr       (rr_ptr_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Pending/polarity/overflow next state; oldest pending event wins,
    // except a channel being moved into the slot may take the new edge.
    always_comb begin
        pend_nxt_s = pend_r;
        pol_nxt_s  = pol_r;
        ovf_nxt_s  = ovf_r;
        for (int c = 0; c < CHANNELS; c++) begin
            if (clk_en_i && overflow_clr_i[c]) begin
                ovf_nxt_s[c] = 1'b0;
            end else begin
                ovf_nxt_s[c] = ovf_r[c];
            end

            if (edge_s[c]) begin
                if (!pend_r[c] || load_s[c]) begin
                    pend_nxt_s[c] = 1'b1;
                    pol_nxt_s[c]  = rise_s[c];
                end else begin
                    ovf_nxt_s[c]  = 1'b1;
                end
            end else if (load_s[c]) begin
                pend_nxt_s[c] = 1'b0;
            end else begin
                pend_nxt_s[c] = pend_r[c];
            end
        end
    end

    // Output slot, round-robin pointer and sampling next state
    always_comb begin
        valid_nxt_s  = valid_r;
        slot_nxt_s   = slot_r;
        rr_ptr_nxt_s = rr_ptr_r;
        if (grant_s) begin
            valid_nxt_s       = 1'b1;
            slot_nxt_s.chan   = gnt_idx_s;
            slot_nxt_s.rising = pol_r[gnt_idx_s];
            rr_ptr_nxt_s      = gnt_idx_s;
        end else if (clk_en_i && free_s) begin
            valid_nxt_s = 1'b0;
        end else begin
            valid_nxt_s = valid_r;
        end

        if (clk_en_i) begin
            prev_nxt_s   = samp_s;
            primed_nxt_s = 1'b1;
        end else begin
            prev_nxt_s   = prev_r;
            primed_nxt_s = primed_r;
        end
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_r   <= '0;
            primed_r <= 1'b0;
            pend_r   <= '0;
            pol_r    <= '0;
            ovf_r    <= '0;
            valid_r  <= 1'b0;
            slot_r   <= '0;
            rr_ptr_r <= IDX_W'(CHANNELS - 1);
        end else begin
            prev_r   <= prev_nxt_s;
            primed_r <= primed_nxt_s;
            pend_r   <= pend_nxt_s;
            pol_r    <= pol_nxt_s;
            ovf_r    <= ovf_nxt_s;
            valid_r  <= valid_nxt_s;
            slot_r   <= slot_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
        end
    end

    assign evt_valid_o  = valid_r;
    assign evt_chan_o   = slot_r.chan;
    assign evt_rising_o = slot_r.rising;
    assign pending_o    = pend_r;
    assign overflow_o   = ovf_r;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed self-checking bench for edge_event_scheduler (4 channels, no
// synchroniser stages so sense_i changes are seen at the next edge).
module tb_edge_event_scheduler;

    logic       clk_s;
    logic       rst_n_s;
    logic       clk_en_s;
    logic       enable_s;
    logic [3:0] sense_s;
    logic [7:0] edge_sel_s;
    logic       evt_valid_s;
    logic       evt_ready_s;
    logic [1:0] evt_chan_s;
    logic       evt_rising_s;
    logic [3:0] pending_s;
    logic [3:0] overflow_s;
    logic [3:0] ovf_clr_s;

    int checks_total_r;
    int checks_passed_r;

    edge_event_scheduler #(
        .CHANNELS    (4),
        .SYNC_STAGES (0)
    ) dut (
        .clk_i          (clk_s),
        .rst_n_i        (rst_n_s),
        .clk_en_i       (clk_en_s),
        .enable_i       (enable_s),
        .sense_i        (sense_s),
        .edge_sel_i     (edge_sel_s),
        .evt_valid_o    (evt_valid_s),
        .evt_ready_i    (evt_ready_s),
        .evt_chan_o     (evt_chan_s),
        .evt_rising_o   (evt_rising_s),
        .pending_o      (pending_s),
        .overflow_o     (overflow_s),
        .overflow_clr_i (ovf_clr_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total_r++;
        if (obs === exp) begin
            checks_passed_r++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic check_evt(input string tag, input logic v, input logic [1:0] ch, input logic r);
        check_eq({tag, "_valid"}, 32'(evt_valid_s), 32'(v));
        check_eq({tag, "_chan"},  32'(evt_chan_s),  32'(ch));
        check_eq({tag, "_rising"}, 32'(evt_rising_s), 32'(r));
    endtask

    initial begin
        logic any_valid;
        logic hold_ok;
        checks_total_r  = 0;
        checks_passed_r = 0;

        // Reset with all lines high, all channels on both edges
        rst_n_s     = 1'b0;
        clk_en_s    = 1'b1;
        enable_s    = 1'b1;
        sense_s     = 4'b1111;
        edge_sel_s  = 8'hFF;
        evt_ready_s = 1'b0;
        ovf_clr_s   = 4'b0000;
        step();
        step();
        check_evt("rst", 1'b0, 2'd0, 1'b0);
        check_eq("rst_pending",  32'(pending_s),  32'h0);
        check_eq("rst_overflow", 32'(overflow_s), 32'h0);

        // High lines at release must not produce events
        rst_n_s   = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            any_valid = any_valid | evt_valid_s;
        end
        check_eq("prime_novalid", 32'(any_valid), 32'h0);
        check_eq("prime_pending", 32'(pending_s), 32'h0);

        // Ch2 rising only, ready held high; falling edge ignored
        edge_sel_s  = 8'h10;
        evt_ready_s = 1'b1;
        sense_s     = 4'b1011;
        step();
        step();
        check_eq("fall_ign_pending", 32'(pending_s), 32'h0);
        check_eq("fall_ign_valid",   32'(evt_valid_s), 32'h0);
        sense_s = 4'b1111;
        step();
        check_eq("lat_t1_pending", 32'(pending_s), 32'h4);
        check_eq("lat_t1_valid",   32'(evt_valid_s), 32'h0);
        step();
        check_evt("lat_t2", 1'b1, 2'd2, 1'b1);
        step();
        check_eq("lat_t3_valid", 32'(evt_valid_s), 32'h0);
        sense_s = 4'b1011;
        step();
        step();
        check_eq("fall2_valid",   32'(evt_valid_s), 32'h0);
        check_eq("fall2_pending", 32'(pending_s),   32'h0);

        // Park rr pointer on ch3 via a single ch3 event
        edge_sel_s = 8'h55;
        sense_s    = 4'b0000;
        step();
        sense_s = 4'b1000;
        step();
        step();
        check_evt("ch3", 1'b1, 2'd3, 1'b1);
        step();
        check_eq("ch3_done", 32'(evt_valid_s), 32'h0);

        // Round robin: ch0, ch1, ch3 rise together with ready low
        evt_ready_s = 1'b0;
        sense_s     = 4'b0000;
        step();
        sense_s = 4'b1011;
        step();
        check_eq("rr_pending", 32'(pending_s), 32'hB);
        step();
        check_evt("rr_first", 1'b1, 2'd0, 1'b1);
        check_eq("rr_pending2", 32'(pending_s), 32'hA);
        step();
        check_evt("rr_hold", 1'b1, 2'd0, 1'b1);
        evt_ready_s = 1'b1;
        step();
        check_evt("rr_second", 1'b1, 2'd1, 1'b1);
        step();
        check_evt("rr_third", 1'b1, 2'd3, 1'b1);
        step();
        check_eq("rr_drained", 32'(evt_valid_s), 32'h0);
        evt_ready_s = 1'b0;

        // Overflow on ch1 while the slot is busy with a ch0 event
        edge_sel_s = 8'h00;
        sense_s    = 4'b0000;
        step();
        edge_sel_s = 8'h0D;
        sense_s    = 4'b0001;
        step();
        step();
        check_evt("ovf_slot", 1'b1, 2'd0, 1'b1);
        sense_s = 4'b0011;
        step();
        check_eq("ovf_pend1", 32'(pending_s),  32'h2);
        check_eq("ovf_none",  32'(overflow_s), 32'h0);
        sense_s = 4'b0001;
        step();
        check_eq("ovf_set",   32'(overflow_s), 32'h2);
        check_eq("ovf_kept",  32'(pending_s),  32'h2);
        evt_ready_s = 1'b1;
        step();
        check_evt("ovf_oldest", 1'b1, 2'd1, 1'b1);
        evt_ready_s = 1'b0;
        ovf_clr_s   = 4'b0010;
        step();
        check_eq("ovf_clr", 32'(overflow_s), 32'h0);
        ovf_clr_s = 4'b0000;
        sense_s   = 4'b0011;
        step();
        sense_s   = 4'b0001;
        ovf_clr_s = 4'b0010;
        step();
        check_eq("ovf_set_wins", 32'(overflow_s), 32'h2);
        ovf_clr_s = 4'b0000;

        // clk_en low: nothing moves, clear ignored, transient edges lost
        clk_en_s    = 1'b0;
        evt_ready_s = 1'b1;
        ovf_clr_s   = 4'b0010;
        hold_ok     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sense_s = (i % 2 == 0) ? 4'b0011 : 4'b0000;
            step();
            if (!(evt_valid_s === 1'b1 && evt_chan_s === 2'd1 &&
                  overflow_s === 4'b0010 && pending_s === 4'b0010)) begin
                hold_ok = 1'b0;
            end
        end
        check_eq("clken_hold", 32'(hold_ok), 32'h1);
        sense_s     = 4'b0001;
        #2;
        clk_en_s    = 1'b1;
        evt_ready_s = 1'b0;
        ovf_clr_s   = 4'b0000;
        step();
        check_evt("clken_after", 1'b1, 2'd1, 1'b1);
        check_eq("clken_pending",  32'(pending_s),  32'h2);
        check_eq("clken_overflow", 32'(overflow_s), 32'h2);

        // Asynchronous reset mid-stream, then ch0 wins from reset pointer
        sense_s = 4'b0000;
        step();
        sense_s = 4'b0001;
        step();
        check_eq("pre_rst_pending", 32'(pending_s), 32'h3);
        check_eq("pre_rst_valid",   32'(evt_valid_s), 32'h1);
        #2;
        rst_n_s = 1'b0;
        #1;
        check_evt("async_rst", 1'b0, 2'd0, 1'b0);
        check_eq("async_rst_pending",  32'(pending_s),  32'h0);
        check_eq("async_rst_overflow", 32'(overflow_s), 32'h0);
        step();
        edge_sel_s = 8'h55;
        sense_s    = 4'b0000;
        rst_n_s    = 1'b1;
        step();
        sense_s = 4'b1001;
        step();
        check_eq("post_rst_pending", 32'(pending_s), 32'h9);
        step();
        check_evt("post_rst_first", 1'b1, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", checks_passed_r, checks_total_r);
        $finish;
    end

endmodule
